// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 geometry for the VGA timing generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    localparam int COUNT_W = 10;

    localparam int DEF_TOTAL_COLS       = 800;
    localparam int DEF_TOTAL_ROWS       = 525;
    localparam int DEF_ACTIVE_COLS      = 640;
    localparam int DEF_ACTIVE_ROWS      = 480;
    localparam int DEF_FRONT_PORCH_HORZ = 18;
    localparam int DEF_BACK_PORCH_HORZ  = 50;
    localparam int DEF_FRONT_PORCH_VERT = 10;
    localparam int DEF_BACK_PORCH_VERT  = 33;

endpackage

// File: rtl/vga_axis_fsm.sv
// One timing axis: position counter plus phase FSM that tracks the region the count sits in.
//
// state  | meaning
// ACTIVE | count in visible region
// FRONT  | front porch
// SYNC   | sync pulse region
// BACK   | back porch, returns to ACTIVE on wrap
module vga_axis_fsm
    import vga_timing_pkg::*;
#(
    parameter int TOTAL       = DEF_TOTAL_COLS,
    parameter int ACTIVE_LEN  = DEF_ACTIVE_COLS,
    parameter int FRONT_PORCH = DEF_FRONT_PORCH_HORZ,
    parameter int BACK_PORCH  = DEF_BACK_PORCH_HORZ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    output logic [COUNT_W-1:0] count,
    output phase_t             phase,
    output logic               wrap
);

    localparam logic [COUNT_W-1:0] ACTIVE_LAST = COUNT_W'(ACTIVE_LEN - 1);
    localparam logic [COUNT_W-1:0] FRONT_LAST  = COUNT_W'(ACTIVE_LEN + FRONT_PORCH - 1);
    localparam logic [COUNT_W-1:0] SYNC_LAST   = COUNT_W'(TOTAL - BACK_PORCH - 1);
    localparam logic [COUNT_W-1:0] LAST        = COUNT_W'(TOTAL - 1);

    logic [COUNT_W-1:0] count_next;
    phase_t             phase_next;

    assign wrap = advance && (count == LAST);

    // Phase changes as the count leaves the last position of a region, so phase always matches count.
    always_comb begin
        count_next = count;
        phase_next = phase;
        if (advance) begin
            count_next = wrap ? '0 : count + COUNT_W'(1);
            case (phase)
                ACTIVE:  if (count == ACTIVE_LAST) phase_next = FRONT;
                FRONT:   if (count == FRONT_LAST)  phase_next = SYNC;
                SYNC:    if (count == SYNC_LAST)   phase_next = BACK;
                BACK:    if (wrap)                 phase_next = ACTIVE;
                default: phase_next = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            phase <= ACTIVE;
        end else begin
            count <= count_next;
            phase <= phase_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blanking generator; syncs, active, frame start and video lag the counts by one cycle.
// Optional VGA_TIMING_TEST_PATTERN_EN adds i_Pattern_Sel and an 8-bar colour pattern.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int VIDEO_WIDTH      = 3,
    parameter int TOTAL_COLS       = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS       = DEF_TOTAL_ROWS,
    parameter int ACTIVE_COLS      = DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS      = DEF_ACTIVE_ROWS,
    parameter int FRONT_PORCH_HORZ = DEF_FRONT_PORCH_HORZ,
    parameter int BACK_PORCH_HORZ  = DEF_BACK_PORCH_HORZ,
    parameter int FRONT_PORCH_VERT = DEF_FRONT_PORCH_VERT,
    parameter int BACK_PORCH_VERT  = DEF_BACK_PORCH_VERT
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Enable,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    input  logic                   i_Pattern_Sel,
`endif
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic [COUNT_W-1:0]     o_Col_Count,
    output logic [COUNT_W-1:0]     o_Row_Count,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic                   o_Active,
    output logic                   o_Frame_Start,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

    phase_t h_phase, v_phase;
    logic   h_wrap, v_wrap;
    logic   origin;
    logic   active;
    logic [VIDEO_WIDTH-1:0] red_src, grn_src, blu_src;

    vga_axis_fsm #(
        .TOTAL(TOTAL_COLS), .ACTIVE_LEN(ACTIVE_COLS),
        .FRONT_PORCH(FRONT_PORCH_HORZ), .BACK_PORCH(BACK_PORCH_HORZ)
    ) u_horz (
        .clk(i_Clk), .reset(i_Reset), .advance(i_Enable),
        .count(o_Col_Count), .phase(h_phase), .wrap(h_wrap)
    );

    vga_axis_fsm #(
        .TOTAL(TOTAL_ROWS), .ACTIVE_LEN(ACTIVE_ROWS),
        .FRONT_PORCH(FRONT_PORCH_VERT), .BACK_PORCH(BACK_PORCH_VERT)
    ) u_vert (
        .clk(i_Clk), .reset(i_Reset), .advance(h_wrap),
        .count(o_Row_Count), .phase(v_phase), .wrap(v_wrap)
    );

    assign active = (h_phase == ACTIVE) && (v_phase == ACTIVE);

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [COUNT_W+2:0] col_x8;
    logic [2:0]         bar;

    assign col_x8  = {o_Col_Count, 3'b000};
    assign bar     = 3'(32'(col_x8) / ACTIVE_COLS);
    assign red_src = i_Pattern_Sel ? {VIDEO_WIDTH{bar[2]}} : i_Red_Video;
    assign grn_src = i_Pattern_Sel ? {VIDEO_WIDTH{bar[1]}} : i_Grn_Video;
    assign blu_src = i_Pattern_Sel ? {VIDEO_WIDTH{bar[0]}} : i_Blu_Video;
`else
    assign red_src = i_Red_Video;
    assign grn_src = i_Grn_Video;
    assign blu_src = i_Blu_Video;
`endif

    // Flags that the counters currently sit at (0,0); avoids a full-width compare of both counts.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            origin <= 1'b1;
        end else if (i_Enable) begin
            origin <= v_wrap;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset || !i_Enable) begin
            o_HSync       <= 1'b1;
            o_VSync       <= 1'b1;
            o_Active      <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Red_Video   <= '0;
            o_Grn_Video   <= '0;
            o_Blu_Video   <= '0;
        end else begin
            o_HSync       <= (h_phase != SYNC);
            o_VSync       <= (v_phase != SYNC);
            o_Active      <= active;
            o_Frame_Start <= origin;
            o_Red_Video   <= active ? red_src : '0;
            o_Grn_Video   <= active ? grn_src : '0;
            o_Blu_Video   <= active ? blu_src : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen; full horizontal geometry with a shortened 20-line frame.
module tb_vga_timing_gen;

    localparam int TC  = 800;
    localparam int TR  = 20;
    localparam int AC  = 640;
    localparam int AR  = 12;
    localparam int FPH = 18;
    localparam int BPH = 50;
    localparam int FPV = 3;
    localparam int BPV = 3;
    localparam int VW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          pat_sel = 1'b0;
    logic [VW-1:0] ri = '0, gi = '0, bi = '0;
    logic [9:0]    col, row;
    logic          hs, vs, act, fs;
    logic [VW-1:0] ro, go, bo;

    int passed = 0;
    int total  = 0;

    // reference model: linear pixel index plus expected registered outputs
    int            pos = 0;
    logic          e_hs = 1'b1, e_vs = 1'b1, e_act = 1'b0, e_fs = 1'b0;
    logic [VW-1:0] e_r = '0, e_g = '0, e_b = '0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
        .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .FRONT_PORCH_HORZ(FPH), .BACK_PORCH_HORZ(BPH),
        .FRONT_PORCH_VERT(FPV), .BACK_PORCH_VERT(BPV)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Enable(en),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .i_Pattern_Sel(pat_sel),
`endif
        .i_Red_Video(ri),
        .i_Grn_Video(gi),
        .i_Blu_Video(bi),
        .o_Col_Count(col),
        .o_Row_Count(row),
        .o_HSync(hs),
        .o_VSync(vs),
        .o_Active(act),
        .o_Frame_Start(fs),
        .o_Red_Video(ro),
        .o_Grn_Video(go),
        .o_Blu_Video(bo)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // one clock: advance the model from the inputs seen at the edge, then compare everything
    task automatic step();
        int c, r, bar;
        logic a;
        c = pos % TC;
        r = pos / TC;
        @(posedge clk);
        if (rst || !en) begin
            if (rst) pos = 0;
            e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_fs = 1'b0;
            e_r = '0; e_g = '0; e_b = '0;
        end else begin
            a     = (c < AC) && (r < AR);
            e_hs  = !((c >= AC + FPH) && (c < TC - BPH));
            e_vs  = !((r >= AR + FPV) && (r < TR - BPV));
            e_act = a;
            e_fs  = (pos == 0);
            bar   = (c * 8) / AC;
            if (!a) begin
                e_r = '0; e_g = '0; e_b = '0;
            end else if (pat_sel) begin
                e_r = bar[2] ? '1 : '0;
                e_g = bar[1] ? '1 : '0;
                e_b = bar[0] ? '1 : '0;
            end else begin
                e_r = ri; e_g = gi; e_b = bi;
            end
            pos = (pos + 1) % (TC * TR);
        end
        #1;
        check("model", {31'd0, col, row, hs, vs, act, fs, ro, go, bo},
              {31'd0, 10'(pos % TC), 10'(pos / TC), e_hs, e_vs, e_act, e_fs, e_r, e_g, e_b});
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        en  = 1'b1;
        step();
        step();
        check("reset", {col, row, hs, vs, act, fs, ro, go, bo}, {10'd0, 10'd0, 4'b1100, 9'd0});
        rst = 1'b0;
    endtask

    typedef struct {
        int   k;
        int   c;
        int   r;
        logic hs;
        logic vs;
        logic act;
        logic fs;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int idx, fs_cnt, hrun, hpulses, hbad, vlow, vid, coinc_bad;

        // k = enabled edges since reset release; outputs describe position k-1
        tbl.push_back('{1,     1,   0,  1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{2,     2,   0,  1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{640,   640, 0,  1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{641,   641, 0,  1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{658,   658, 0,  1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{659,   659, 0,  1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{750,   750, 0,  1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{751,   751, 0,  1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{800,   0,   1,  1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{801,   1,   1,  1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{9601,  1,   12, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{12000, 0,   15, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{12001, 1,   15, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{13600, 0,   17, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{13601, 1,   17, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{16000, 0,   0,  1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{16001, 1,   0,  1'b1, 1'b1, 1'b1, 1'b1});

        // full frame with constant white video, table vectors and frame statistics
        ri = '1; gi = '1; bi = '1;
        reset_dut();
        idx = 0; fs_cnt = 0; hrun = 0; hpulses = 0; hbad = 0; vlow = 0; vid = 0; coinc_bad = 0;
        for (int k = 1; k <= TC * TR + 1; k++) begin
            step();
            if (k <= TC * TR) begin
                if (fs) fs_cnt++;
                if (!hs) hrun++;
                else if (hrun > 0) begin
                    hpulses++;
                    if (hrun != TC - BPH - AC - FPH) hbad++;
                    hrun = 0;
                end
                if (!vs) vlow++;
                if ({ro, go, bo} != '0) vid++;
                if (({ro, go, bo} != '0) != act) coinc_bad++;
            end
            if (idx < tbl.size() && tbl[idx].k == k) begin
                check($sformatf("vec_k%0d", k), {col, row, hs, vs, act, fs, ro, go, bo},
                      {10'(tbl[idx].c), 10'(tbl[idx].r), tbl[idx].hs, tbl[idx].vs,
                       tbl[idx].act, tbl[idx].fs, (tbl[idx].act ? 9'h1FF : 9'h000)});
                idx++;
            end
        end
        check("frame_start_count", fs_cnt, 1);
        check("hsync_pulses", hpulses, 20);
        check("hsync_bad_width", hbad, 0);
        check("vsync_low_cycles", vlow, 2 * 800);
        check("video_cycles", vid, 640 * 12);
        check("video_vs_active", coinc_bad, 0);

        // enable dropped at (100,10) for 50 cycles
        reset_dut();
        repeat (10 * 800 + 100) step();
        check("pre_hold_pos", {col, row}, {10'd100, 10'd10});
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check("hold", {col, row, hs, vs, act, fs, ro, go, bo}, {10'd100, 10'd10, 4'b1100, 9'd0});
        end
        en = 1'b1;
        step();
        check("resume", {col, row, act, ro, go, bo}, {10'd101, 10'd10, 1'b1, 9'h1FF});

        // reset in the last vsync line at column 700
        reset_dut();
        repeat (16 * 800 + 700) step();
        check("pre_reset", {col, row, vs}, {10'd700, 10'd16, 1'b0});
        rst = 1'b1;
        step();
        check("mid_reset", {col, row, hs, vs, act, fs}, {10'd0, 10'd0, 4'b1100});
        rst = 1'b0;
        step();
        check("post_reset_fs", {col, row, fs}, {10'd1, 10'd0, 1'b1});
        step();
        check("post_reset_fs_off", fs, 1'b0);

        // randomized run against the model
        reset_dut();
        for (int i = 0; i < 15000; i++) begin
            rst = ($urandom_range(0, 799) == 0);
            en  = ($urandom_range(0, 3) != 0);
            ri  = VW'($urandom);
            gi  = VW'($urandom);
            bi  = VW'($urandom);
            step();
        end
        rst = 1'b0;
        en  = 1'b1;

`ifdef VGA_TIMING_TEST_PATTERN_EN
        reset_dut();
        pat_sel = 1'b1;
        for (int k = 1; k <= 640; k++) begin
            ri = VW'($urandom); gi = VW'($urandom); bi = VW'($urandom);
            step();
            if (k == 1)   check("pat_col0",   {ro, go, bo}, 9'o000);
            if (k == 81)  check("pat_col80",  {ro, go, bo}, 9'o007);
            if (k == 640) check("pat_col639", {ro, go, bo}, 9'o777);
        end
        pat_sel = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter VIDEO_WIDTH, default 3, bits per colour channel.
REQ-002 Parameters TOTAL_COLS 800, TOTAL_ROWS 525, ACTIVE_COLS 640, ACTIVE_ROWS 480; frame geometry in pixels/lines.
REQ-003 Parameters FRONT_PORCH_HORZ 18, BACK_PORCH_HORZ 50, FRONT_PORCH_VERT 10, BACK_PORCH_VERT 33; sync width is the remainder (92 cols, 2 rows at defaults).
REQ-004 One clock, i_Clk; reset i_Reset is synchronous and active-high.
REQ-005 i_Clk  in  1  pixel clock.
REQ-006 i_Reset  in  1  synchronous active-high reset.
REQ-007 i_Enable  in  1  run/hold timing.
REQ-008 i_Red_Video, i_Grn_Video, i_Blu_Video  in  VIDEO_WIDTH each  pixel for current o_Col_Count/o_Row_Count.
REQ-009 o_Col_Count, o_Row_Count  out  10 each  current pixel position.
REQ-010 o_HSync, o_VSync  out  1 each  active-low syncs.
REQ-011 o_Active  out  1  high during visible pixels.
REQ-012 o_Frame_Start  out  1  one-cycle pulse at pixel (0,0).
REQ-013 o_Red_Video, o_Grn_Video, o_Blu_Video  out  VIDEO_WIDTH each  blanked video.

Function
REQ-014 Column counter increments per enabled cycle, wraps TOTAL_COLS-1 -> 0; row counter increments only on column wrap, wraps TOTAL_ROWS-1 -> 0.
REQ-015 i_Enable low: counters hold, o_HSync/o_VSync driven 1, o_Active 0, video 0, o_Frame_Start 0.
REQ-016 Horizontal FSM states H_ACTIVE (col < ACTIVE_COLS), H_FRONT (< ACTIVE_COLS+FRONT_PORCH_HORZ), H_SYNC (< TOTAL_COLS-BACK_PORCH_HORZ), H_BACK (rest); transitions on count boundaries only, H_BACK -> H_ACTIVE on wrap.
REQ-017 Vertical FSM states V_ACTIVE, V_FRONT, V_SYNC, V_BACK with same rule on row count, advancing only on column wrap.
REQ-018 o_HSync low exactly in H_SYNC (cols 658..749 default); o_VSync low exactly in V_SYNC (rows 490..491 default), for the full line width.
REQ-019 o_Active = H_ACTIVE and V_ACTIVE.
REQ-020 Latency: o_HSync, o_VSync, o_Active, o_Frame_Start and video are registered 1 cycle after the o_Col_Count/o_Row_Count value they describe; all five stay mutually aligned.
REQ-021 Video outputs = registered inputs when active, else 0.
REQ-022 Counter widths 10 bits; TOTAL_COLS/TOTAL_ROWS up to 1024.

Reset
REQ-023 i_Reset high: counts 0, FSMs in H_ACTIVE/V_ACTIVE, o_HSync=o_VSync=1, o_Active=0, o_Frame_Start=0, video 0; takes priority over i_Enable.
REQ-024 Reset mid-frame: next cycle after release shows count (0,0); o_Frame_Start pulses one cycle later (if enabled).

Configuration
REQ-025 Macro VGA_TIMING_TEST_PATTERN_EN defined: adds input i_Pattern_Sel (1 bit); when high, video inputs ignored; bar = (col*8)/ACTIVE_COLS; R, G, B all bits = bar[2], bar[1], bar[0]; blanking rules unchanged.
REQ-026 Macro undefined: no i_Pattern_Sel port, no pattern logic.

Structure
REQ-027 Package vga_timing_pkg: phase enum (ACTIVE, FRONT, SYNC, BACK), default geometry constants.
REQ-028 Sub-module vga_axis_fsm (counter + phase FSM, parameterised by total/active/porches, with advance input and wrap output), instantiated for horizontal and vertical.

Verification
REQ-029 Reset, then enable 800*525 cycles -> exactly one o_Frame_Start, 525 o_HSync low pulses each 92 cycles, one o_VSync low of 2*800 cycles.
REQ-030 At o_Col_Count=657/658 -> o_HSync high then low one cycle later; at 750 -> high one cycle later.
REQ-031 Inputs R=G=B=3'b111 constant -> video nonzero exactly 640*480 cycles per frame, coincident with o_Active.
REQ-032 Drop i_Enable at (100,10) for 50 cycles -> counts hold at (100,10), syncs 1, video 0; resume continues from 101.
REQ-033 Assert i_Reset at (700,491) -> next cycle counts (0,0), o_VSync=1, o_HSync=1.
REQ-034 With VGA_TIMING_TEST_PATTERN_EN, i_Pattern_Sel=1 -> col 0 video 0, col 80 blue=3'b111 only, col 639 all 3'b111.
